id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register sitting directly downstream of the register file.
- Captures BusA/BusB and the decoded instruction fields each cycle.
- Applies write-back bypass for same-cycle writes, because the register file updates only at the clock edge.
- Detects load-use hazards, inserts bubbles, and honours external freeze/flush; counts inserted bubbles.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.
- CNT_W, 16, bubble counter width.

Ports:
- CLK in 1: clock, all state on rising edge.
- Reset_L in 1: reset, asynchronous, active-low.
- valid_D in 1: ID-stage instruction valid.
- rs_D in REG_AW: source register 1.
- rt_D in REG_AW: source register 2.
- rd_D in REG_AW: R-type destination.
- useRs_D in 1: instruction reads rs.
- useRt_D in 1: instruction reads rt.
- imm_D in DATA_W: sign/zero-extended immediate.
- ctrl_D in ctrl_t: decoded control bundle.
- BusA in DATA_W: register-file read of rs_D.
- BusB in DATA_W: register-file read of rt_D.
- rw5 in REG_AW: write-back destination, same signal as driven to the register file.
- regWrite5 in 1: write-back enable.
- Busw in DATA_W: write-back data.
- stall_ext in 1: downstream freeze; hold EX contents.
- flush_E in 1: kill the instruction entering EX (branch mispredict).
- stall_D out 1: hold PC/IF/ID this cycle.
- valid_E out 1: EX instruction valid.
- rs_E out REG_AW: registered rs.
- rt_E out REG_AW: registered rt.
- dst_E out REG_AW: registered destination register.
- A_E out DATA_W: operand A.
- B_E out DATA_W: operand B.
- imm_E out DATA_W: registered immediate.
- ctrl_E out ctrl_t: registered control bundle.
- bubble_cnt out CNT_W: count of load-use bubbles inserted.

Behaviour:
- Reset (Reset_L=0, async): valid_E=0, ctrl_E=CTRL_NOP (all zero), all address/data outputs 0, bubble_cnt=0.
- stall_D is combinational during reset: 0.
- Destination select in ID: dst = ctrl_D.regDst ? rd_D : rt_D; forced to 0 when ctrl_D.regWrite=0.
- Bypass:
  - opA = (regWrite5 && rw5!=0 && rw5==rs_D) ? Busw : BusA.
  - opB is the same rule with rt_D.
  - Register 0 is never bypassed.
- Load-use hazard (combinational):
  - lu = valid_E && ctrl_E.memRead && dst_E!=0 && valid_D && ((useRs_D && rs_D==dst_E) || (useRt_D && rt_D==dst_E)).
- stall_D = stall_ext || (lu && !flush_E).
- Per-edge priority, highest first:
  1. flush_E: valid_E=0, ctrl_E=CTRL_NOP, dst_E=0. Data outputs are don't-care; the implementation drives 0.
  2. stall_ext: every EX register holds its value.
  3. lu: insert bubble (valid_E=0, ctrl_E=CTRL_NOP, dst_E=0) and increment bubble_cnt. The ID instruction stays upstream and is re-presented next cycle.
  4. Otherwise capture: valid_E=valid_D, rs/rt/dst/imm/ctrl from ID, A_E=opA, B_E=opB. When valid_D=0, ctrl_E=CTRL_NOP.
- Latency: one cycle from ID inputs to EX outputs.
- bubble_cnt saturates at all-ones and never wraps. It is not incremented on flush or hold cycles.
- A load followed by a dependent instruction produces exactly one bubble. On the following cycle dst_E is 0, so lu clears.
- A bypass when stall_ext=1 has no effect, because the registers hold.

Decomposition:
- Package mips_pkg holds:
  - ctrl_t packed struct: regWrite, memRead, memWrite, memToReg, aluSrc, regDst, aluOp[3:0].
  - CTRL_NOP constant.
  - REG_ZERO constant.
- One sub-module, wb_bypass, instanced twice: inputs sel, rw5, regWrite5, Busw, bus; output operand.

Test Plan:
- Reset mid-operation: with valid_E=1, drop Reset_L between edges -> outputs zero immediately, no clock needed.
- Bypass: rs_D=5, BusA=0x11, rw5=5, regWrite5=1, Busw=0xAB -> A_E=0xAB. Repeat with rw5=0 -> A_E=BusA.
- Load-use: lw to r8 in EX, next add with rs_D=8 and useRs_D=1 -> stall_D=1 for one cycle, one bubble, bubble_cnt=1. Next cycle the add captures.
- Load-use with useRt_D=0 and rt_D=8 -> no stall.
- Simultaneous flush_E and lu -> stall_D=0, valid_E=0, bubble_cnt unchanged.
- stall_ext=1 for 3 cycles with changing ID inputs -> EX outputs constant and stall_D=1 throughout.
- Saturation: with CNT_W=2, force 5 bubbles -> bubble_cnt=3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared decode types for the MIPS ID/EX boundary.
// Pure type/constant package: no latency, no flow control.
package mips_pkg;

   typedef struct packed {
      logic       regWrite;
      logic       memRead;
      logic       memWrite;
      logic       memToReg;
      logic       aluSrc;
      logic       regDst;
      logic [3:0] aluOp;
   } ctrl_t;

   localparam ctrl_t      CTRL_NOP = '0;
   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_bypass.sv
// Write-back bypass mux: substitutes Busw when the register read in ID is being written back this cycle.
// Combinational, zero latency; no flow control.
module wb_bypass import mips_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] sel,
   input  logic [REG_AW-1:0] rw5,
   input  logic              regWrite5,
   input  logic [DATA_W-1:0] Busw,
   input  logic [DATA_W-1:0] bus,
   output logic [DATA_W-1:0] operand
);

   // r0 is hard-wired zero, so a write-back aimed at it must never leak through
   assign operand = (regWrite5 && (rw5 != REG_AW'(REG_ZERO)) && (rw5 == sel)) ? Busw : bus;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with write-back bypass, load-use bubble insertion and a saturating bubble counter.
// One-cycle latency; stall_ext holds every EX register, flush_E beats stall_ext beats load-use.
module id_ex_stage import mips_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              Reset_L,
   input  logic              valid_D,
   input  logic [REG_AW-1:0] rs_D,
   input  logic [REG_AW-1:0] rt_D,
   input  logic [REG_AW-1:0] rd_D,
   input  logic              useRs_D,
   input  logic              useRt_D,
   input  logic [DATA_W-1:0] imm_D,
   input  ctrl_t             ctrl_D,
   input  logic [DATA_W-1:0] BusA,
   input  logic [DATA_W-1:0] BusB,
   input  logic [REG_AW-1:0] rw5,
   input  logic              regWrite5,
   input  logic [DATA_W-1:0] Busw,
   input  logic              stall_ext,
   input  logic              flush_E,
   output logic              stall_D,
   output logic              valid_E,
   output logic [REG_AW-1:0] rs_E,
   output logic [REG_AW-1:0] rt_E,
   output logic [REG_AW-1:0] dst_E,
   output logic [DATA_W-1:0] A_E,
   output logic [DATA_W-1:0] B_E,
   output logic [DATA_W-1:0] imm_E,
   output ctrl_t             ctrl_E,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic [DATA_W-1:0] opA;
   logic [DATA_W-1:0] opB;
   logic [REG_AW-1:0] dst_D;
   logic              lu;

   wb_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_a (
      .sel(rs_D), .rw5(rw5), .regWrite5(regWrite5), .Busw(Busw), .bus(BusA), .operand(opA)
   );

   wb_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_b (
      .sel(rt_D), .rw5(rw5), .regWrite5(regWrite5), .Busw(Busw), .bus(BusB), .operand(opB)
   );

   assign dst_D = !ctrl_D.regWrite ? '0 : (ctrl_D.regDst ? rd_D : rt_D);

   assign lu = valid_E && ctrl_E.memRead && (dst_E != REG_AW'(REG_ZERO)) && valid_D &&
               ((useRs_D && (rs_D == dst_E)) || (useRt_D && (rt_D == dst_E)));

   // A flushed consumer needs no bubble, so the upstream must not hold for it
   assign stall_D = Reset_L && (stall_ext || (lu && !flush_E));

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         valid_E    <= 1'b0;
         rs_E       <= '0;
         rt_E       <= '0;
         dst_E      <= '0;
         A_E        <= '0;
         B_E        <= '0;
         imm_E      <= '0;
         ctrl_E     <= CTRL_NOP;
         bubble_cnt <= '0;
      end else if (flush_E || (!stall_ext && lu)) begin
         valid_E <= 1'b0;
         rs_E    <= '0;
         rt_E    <= '0;
         dst_E   <= '0;
         A_E     <= '0;
         B_E     <= '0;
         imm_E   <= '0;
         ctrl_E  <= CTRL_NOP;
         if (!flush_E && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end else if (!stall_ext) begin
         valid_E <= valid_D;
         rs_E    <= rs_D;
         rt_E    <= rt_D;
         dst_E   <= dst_D;
         A_E     <= opA;
         B_E     <= opB;
         imm_E   <= imm_D;
         ctrl_E  <= valid_D ? ctrl_D : CTRL_NOP;
      end
   end

endmodule
